// File: rtl/mips_wb_pkg.sv
// Shared write-back constants: destination-select codes and register file geometry.
package mips_wb_pkg;
  localparam int         DATA_W     = 32;
  localparam int         REG_AW     = 5;
  localparam int         NREGS      = 32;
  localparam logic [4:0] RA_IDX     = 5'd31;
  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_RA  = 2'b10;
  localparam logic [1:0] REGDST_ILL = 2'b11;
endpackage

// File: rtl/wb_dest_decode.sv
// Combinational destination decode: regDst code plus rt/rd fields -> register index and legal flag.
module wb_dest_decode
  import mips_wb_pkg::*;
#(
  parameter logic [REG_AW-1:0] RA = RA_IDX
) (
  input  logic [1:0]        reg_dst_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic [REG_AW-1:0] dest_o,
  output logic              legal_o
);

  always_comb begin
    dest_o  = '0;
    legal_o = 1'b1;
    case (reg_dst_i)
      REGDST_RT: dest_o = rt_i;
      REGDST_RD: dest_o = rd_i;
      REGDST_RA: dest_o = RA;
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_file_wb.sv
// MIPS register file with a one-entry commit stage; read ports bypass the staged write, debug port does not.
module reg_file_wb
  import mips_wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int RA_IDX = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [1:0]        wb_reg_dst,
  input  logic [REG_AW-1:0] wb_rt,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       commit_count,
  output logic              illegal_dst
);

  logic [REG_AW-1:0] dest;
  logic              legal;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              stage_valid_q, stage_valid_d;
  logic [REG_AW-1:0] stage_addr_q;
  logic [DATA_W-1:0] stage_data_q;
  logic [31:0]       commit_count_q, commit_count_d;
  logic              illegal_q, illegal_d;
  logic              commit;

  wb_dest_decode #(.RA(REG_AW'(RA_IDX))) u_dec (
    .reg_dst_i (wb_reg_dst),
    .rt_i      (wb_rt),
    .rd_i      (wb_rd),
    .dest_o    (dest),
    .legal_o   (legal)
  );

  // Writes to $zero are dropped at commit, so they never reach the array or the count.
  assign commit         = stage_valid_q && (stage_addr_q != '0);
  assign stage_valid_d  = wb_valid && legal;
  assign commit_count_d = commit ? commit_count_q + 32'd1 : commit_count_q;
  assign illegal_d      = illegal_q || (wb_valid && !legal);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      stage_valid_q  <= 1'b0;
      stage_addr_q   <= '0;
      stage_data_q   <= '0;
      commit_count_q <= '0;
      illegal_q      <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      if (stage_valid_d) begin
        stage_addr_q <= dest;
        stage_data_q <= wb_data;
      end
      if (commit) regs_q[stage_addr_q] <= stage_data_q;
      commit_count_q <= commit_count_d;
      illegal_q      <= illegal_d;
    end
  end

  always_comb begin
    rs_data = '0;
    if (rs_addr != '0)
      rs_data = (stage_valid_q && stage_addr_q == rs_addr) ? stage_data_q : regs_q[rs_addr];
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != '0)
      rt_data = (stage_valid_q && stage_addr_q == rt_addr) ? stage_data_q : regs_q[rt_addr];
  end

  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) dbg_data = regs_q[dbg_addr];
  end

  assign commit_count = commit_count_q;
  assign illegal_dst  = illegal_q;

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Register-file side of the write-back interface: receives the selected write-back word plus destination-select code and commits it into a 32 x 32-bit MIPS register file.
- Decodes the destination (rt / rd / $ra), holds the write in a one-entry commit stage and serves two combinational operand read ports plus a debug port, with bypass from the commit stage.
- Sits between the write-back data mux and the decode stage.

Parameters:
- DATA_W, 32, register width
- NREGS, 32, register count (address width fixed at 5)
- RA_IDX, 31, link register index for regDst = 2'b10

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- wb_valid  in  1  write-back request this cycle
- wb_reg_dst  in  2  00 = rt, 01 = rd, 10 = RA_IDX, 11 = illegal
- wb_rt  in  5  rt field of retiring instruction
- wb_rd  in  5  rd field of retiring instruction
- wb_data  in  32  write-back word from the data-to-register mux
- rs_addr  in  5  read port A address
- rs_data  out  32  read port A data
- rt_addr  in  5  read port B address
- rt_data  out  32  read port B data
- dbg_addr  in  5  debug read address
- dbg_data  out  32  debug read data, no bypass
- commit_count  out  32  number of committed non-zero-destination writes
- illegal_dst  out  1  sticky, set on wb_valid with wb_reg_dst = 11

Behaviour:
- Reset: one clock, synchronous, active-low; the polarity and synchronicity are fixed.
  - On a clk edge with rst_n = 0: all registers = 0, stage_valid = 0, commit_count = 0, illegal_dst = 0.
  - Consequence: rs_data, rt_data and dbg_data read 0 in the cycle after reset.
  - Reset mid-operation discards any staged write.
- Destination decode, combinational on inputs: 00 -> wb_rt, 01 -> wb_rd, 10 -> RA_IDX.
  - 11 -> no write; sets illegal_dst at the edge.
- Stage 1 (accept):
  - On the edge where wb_valid = 1 and the code is legal: stage_addr <= dest, stage_data <= wb_data, stage_valid <= 1.
  - Otherwise stage_valid <= 0.
  - No backpressure: one request accepted every cycle.
- Stage 2 (commit):
  - On the edge where stage_valid = 1 and stage_addr != 0: regs[stage_addr] <= stage_data and commit_count increments (wraps 0xFFFFFFFF -> 0).
  - stage_addr = 0 is discarded and not counted.
- Write latency: request at edge E is visible on the read ports from E (through the bypass) and in the array from E+1.
- Read ports, combinational, zero latency:
  - addr = 0 -> 0, always.
  - Else if stage_valid and stage_addr = addr -> stage_data (bypass).
  - Else regs[addr].
- wb_* inputs in the current cycle are never bypassed; they become visible only after the accepting edge.
- Back-to-back writes to the same register: the stage holds the newer value, so reads return the newest; the array receives both in order.
- dbg_data = regs[dbg_addr] with no bypass; register 0 reads 0.
- illegal_dst clears only on reset.

Decomposition:
- Shared package mips_wb_pkg: REGDST_RT = 2'b00, REGDST_RD = 2'b01, REGDST_RA = 2'b10, REGDST_ILL = 2'b11, RA_IDX, DATA_W, REG_AW = 5.
- Natural sub-module wb_dest_decode: combinational 2-bit code plus rt/rd -> 5-bit dest and legal flag.
- The register array and commit stage stay in the top.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges after random writes -> all 32 debug reads 0, commit_count = 0, illegal_dst = 0.
- Decode: wb_reg_dst = 00, rt = 5, data 0x11111111; then 01, rd = 6, 0x22222222; then 10, 0x33333333.
  - Required: regs 5, 6 and 31 hold those values.
  - Required: commit_count = 3 two cycles after the last request.
- Bypass: write 0xDEADBEEF to reg 7 with rs_addr = rt_addr = 7.
  - Cycle of request: reads show old value 0.
  - After the accepting edge: reads show 0xDEADBEEF while dbg_data(7) is still 0.
  - One edge later: dbg_data = 0xDEADBEEF.
- Zero register: write 0xFFFFFFFF to reg 0 via rt = 0 -> rs_data(0) = 0 every cycle, commit_count unchanged.
- Back-to-back writes to reg 9 with 0xA then 0xB in consecutive cycles -> read 0xA, then 0xB, then 0xB stable; commit_count += 2.
- Illegal code: wb_reg_dst = 11, rd = 4, 0x55 -> reg 4 unchanged, illegal_dst = 1 and stays 1 through later legal writes until rst_n = 0.
